hilo_muldiv_unit: RTL and testbench

- Iterative multiply/divide engine that produces the HI/LO writes for MULT, MULTU, DIV and DIVU.
- It is the write-side producer feeding the HI and LO register instances (write-enable plus 32-bit data each).
- It sits beside the EX stage and raises busy so the pipeline stalls while an operation is in flight.
- It is sequential: a 32-iteration radix-2 datapath for both multiply and divide.

---
 rtl/hilo_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative radix-2 multiply/divide engine producing HI/LO register writes for
// MULT, MULTU, DIV and DIVU with a fixed 33-cycle latency.
module hilo_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic              hi_write,
    output logic [DATA_W-1:0] hi_result,
    output logic              lo_write,
    output logic [DATA_W-1:0] lo_result
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic [DATA_W:0]     a_mag_q, a_mag_d;
    logic [DATA_W:0]     b_mag_q, b_mag_d;
    logic [DATA_W-1:0]   a_raw_q, a_raw_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                accept;
    logic                op_signed;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W+1:0]   div_diff;
    logic [2*DATA_W-1:0] prod_fix;

    // Magnitude in DATA_W+1 bits so the most-negative operand keeps its value.
    function automatic logic [DATA_W:0] abs_mag(input logic [DATA_W-1:0] v, input logic is_signed);
        logic [DATA_W:0] ext;
        ext = {is_signed & v[DATA_W-1], v};
        return (is_signed && v[DATA_W-1]) ? -ext : ext;
    endfunction

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            a_raw_q  <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            a_raw_q  <= a_raw_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        a_raw_d   = a_raw_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_fix  = '0;
        op_signed = ~op[0];
        accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !cancel;
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (b_mag_q[0] ? a_mag_q : '0);
        div_diff  = {1'b0, acc_q[2*DATA_W-1:DATA_W-1]} - {1'b0, b_mag_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    is_div_d = op[1];
                    sign_a_d = op_signed & src_a[DATA_W-1];
                    sign_b_d = op_signed & src_b[DATA_W-1];
                    a_mag_d  = abs_mag(src_a, op_signed);
                    b_mag_d  = abs_mag(src_b, op_signed);
                    a_raw_d  = src_a;
                    // Divide starts with the dividend magnitude in the quotient half.
                    acc_d    = op[1] ? {{DATA_W{1'b0}}, a_mag_d[DATA_W-1:0]} : '0;
                    cnt_d    = '0;
                    state_d  = op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (state_q == S_MUL) begin
                    acc_d   = {mul_sum, acc_q[DATA_W-1:1]};
                    b_mag_d = b_mag_q >> 1;
                end else if (!div_diff[DATA_W+1]) begin
                    acc_d = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cancel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DATA_W-1)) begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        prod_fix = cond_neg2(acc_d, sign_a_q ^ sign_b_q);
                        hi_d     = prod_fix[2*DATA_W-1:DATA_W];
                        lo_d     = prod_fix[DATA_W-1:0];
                    end else if (b_mag_q == '0) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = cond_neg(acc_d[2*DATA_W-1:DATA_W], sign_a_q);
                        lo_d = cond_neg(acc_d[DATA_W-1:0], sign_a_q ^ sign_b_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_MUL) || (state_q == S_DIV);
        done      = (state_q == S_DONE) && !cancel;
        hi_write  = done;
        lo_write  = done;
        hi_result = hi_q;
        lo_result = lo_q;
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        hi_write;
    logic [31:0] hi_result;
    logic        lo_write;
    logic [31:0] lo_result;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    hilo_muldiv_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .done(done), .hi_write(hi_write),
        .hi_result(hi_result), .lo_write(lo_write), .lo_result(lo_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Plain-arithmetic reference: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'd0: return sa * sb;
            2'd1: return ua * ub;
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Called shortly after a rising edge; the request is taken at the next edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_done(output logic [31:0] hi, output logic [31:0] lo, output int busy_n,
                             output logic got, output logic we_ok);
        busy_n = 0;
        got    = 1'b0;
        we_ok  = 1'b0;
        hi     = '0;
        lo     = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) begin
                got   = 1'b1;
                hi    = hi_result;
                lo    = lo_result;
                we_ok = hi_write && lo_write && !busy;
            end else begin
                if (busy) busy_n++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi, lo;
        int          bn;
        logic        got, we;
        issue(o, a, b);
        wait_done(hi, lo, bn, got, we);
        check({name, " done seen"}, 64'(got), 64'd1);
        check({name, " hi"}, 64'(hi), 64'(ehi));
        check({name, " lo"}, 64'(lo), 64'(elo));
        check({name, " busy cycles"}, 64'(bn), 64'd32);
        check({name, " write enables"}, 64'(we), 64'd1);
        @(posedge clk); #1;
        check({name, " single pulse"}, 64'({done, hi_write, lo_write}), 64'd0);
    endtask

    initial begin
        logic [31:0] hi, lo;
        int          bn, writes;
        logic        got, we;
        logic [63:0] exp;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{2'd1, 32'd6,         32'd7,         32'd0,         32'd42};
        vecs[10] = '{2'd3, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
        vecs[11] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[12] = '{2'd1, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000};

        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        src_a  = '0;
        src_b  = '0;
        cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, hi_write, lo_write, hi_result, lo_result}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle after reset", {busy, done, hi_write, lo_write, hi_result, lo_result}, 64'd0);

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Back-to-back: DIV -7/2 requested during the DONE cycle of a MULTU.
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(hi, lo, bn, got, we);
        check("b2b first hi", 64'(hi), 64'hFFFF_FFFE);
        check("b2b first lo", 64'(lo), 64'h0000_0001);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        check("b2b accepted", 64'(busy), 64'd1);
        wait_done(hi, lo, bn, got, we);
        check("b2b second seen", 64'(got), 64'd1);
        check("b2b second busy", 64'(bn), 64'd32);
        check("b2b second hi", 64'(hi), 64'hFFFF_FFFF);
        check("b2b second lo", 64'(lo), 64'hFFFF_FFFD);
        @(posedge clk); #1;

        // Cancel during DIV at cycle E0+10.
        writes = 0;
        issue(2'd2, 32'd100, 32'd7);
        for (int k = 1; k < 10; k++) begin
            if (hi_write || lo_write) writes++;
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        #3;
        if (hi_write || lo_write) writes++;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel busy drop", 64'(busy), 64'd0);
        for (int k = 0; k < 40; k++) begin
            if (hi_write || lo_write || done) writes++;
            @(posedge clk); #1;
        end
        check("cancel no writes", 64'(writes), 64'd0);
        check("cancel hi kept", 64'(hi_result), 64'hFFFF_FFFF);
        run_op("after cancel", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14);

        // Cancel during DONE gates the write strobes combinationally.
        issue(2'd1, 32'd3, 32'd4);
        wait_done(hi, lo, bn, got, we);
        check("done-cancel pre", 64'(got), 64'd1);
        cancel = 1'b1;
        #1;
        check("done-cancel gate", 64'({done, hi_write, lo_write}), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        check("done-cancel idle", 64'({busy, done}), 64'd0);
        check("done-cancel lo", 64'(lo_result), 64'd12);

        // Asynchronous reset in the middle of a multiply.
        issue(2'd0, 32'd123, 32'hFFFF_FE38);
        repeat (14) begin
            @(posedge clk); #1;
        end
        #3;
        rst = 1'b1;
        #1;
        check("async reset outputs", {busy, done, hi_write, lo_write, hi_result, lo_result}, 64'd0);
        #2;
        rst = 1'b0;
        writes = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            if (done || hi_write || lo_write || busy) writes++;
            @(posedge clk); #1;
        end
        check("async reset no done", 64'(writes), 64'd0);
        run_op("post reset", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42);

        // Randomized operations against the reference model.
        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                4: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(0, 255)); end
                default: ;
            endcase
            exp = model(ro, ra, rb);
            run_op($sformatf("rand%0d op%0d %h %h", n, ro, ra, rb), ro, ra, rb, exp[63:32], exp[31:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
